ir_prefetch_queue: RTL and testbench

Parametrised successor to the single-entry instruction register: a DEPTH-entry instruction prefetch queue that presents its head entry as decoded opcode and operand fields. It sits between the memory data bus and the control unit. Fetch can run ahead of execution by up to DEPTH words, and the queue can be flushed on a jump. Decoded field outputs are tri-stateable under OE, so the block can share the decode lines like its predecessor.

---
 rtl/ir_prefetch_queue_if.sv | 35 +++
 rtl/ir_prefetch_queue.sv | 80 ++++++++
 tb/tb_ir_prefetch_queue.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ir_prefetch_queue_if.sv
// Bus bundle for the instruction prefetch queue: load/advance/flush controls,
// the data bus word, and the decoded head fields with queue status.
interface ir_prefetch_queue_if #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter int OPCODE_W  = 7,
    parameter int OPERAND_W = 3
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                 notLoad;
    logic                 notAdvance;
    logic                 notFlush;
    logic                 OE;
    logic [WIDTH-1:0]     in;

    // Field lines are shared decode lines, hence nets rather than variables.
    wire  [OPCODE_W-1:0]  outOpcode;
    wire  [OPERAND_W-1:0] outOp0;
    wire  [OPERAND_W-1:0] outOp1;
    wire  [OPERAND_W-1:0] outOp2;
    logic                 valid;
    logic                 full;
    logic [CW-1:0]        count;

    modport master (
        output notLoad, notAdvance, notFlush, OE, in,
        input  outOpcode, outOp0, outOp1, outOp2, valid, full, count
    );

    modport slave (
        input  notLoad, notAdvance, notFlush, OE, in,
        output outOpcode, outOp0, outOp1, outOp2, valid, full, count
    );
endinterface

// File: rtl/ir_prefetch_queue.sv
// DEPTH-entry instruction prefetch queue; the head entry is decoded into
// opcode/operand fields that tri-state under OE.
module ir_prefetch_queue #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter int OPCODE_W  = 7,
    parameter int OPERAND_W = 3
) (
    input logic               clock,
    input logic               notReset,
    ir_prefetch_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (WIDTH != OPCODE_W + 3 * OPERAND_W) begin : g_bad_width
        $error("ir_prefetch_queue: WIDTH must equal OPCODE_W + 3*OPERAND_W");
    end
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ir_prefetch_queue: DEPTH must be a power of two in 2..16");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid, full;
    logic             do_push, do_pop;
    logic [WIDTH-1:0] head;

    assign valid = (count_q != '0);
    assign full  = (count_q == CW'(DEPTH));

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        do_pop  = 1'b0;
        do_push = 1'b0;
        if (!bus.notFlush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            do_pop  = !bus.notAdvance && valid;
            // A full queue still takes a word when the head retires this cycle.
            do_push = !bus.notLoad && (!full || do_pop);
            if (do_push) wptr_d = wptr_q + PW'(1);
            if (do_pop)  rptr_d = rptr_q + PW'(1);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (do_pop && !do_push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wptr_q] <= bus.in;
    end

    assign head = valid ? mem_q[rptr_q] : '0;

    assign bus.outOpcode = bus.OE ? head[WIDTH-1 -: OPCODE_W]        : 'z;
    assign bus.outOp0    = bus.OE ? head[3*OPERAND_W-1 -: OPERAND_W] : 'z;
    assign bus.outOp1    = bus.OE ? head[2*OPERAND_W-1 -: OPERAND_W] : 'z;
    assign bus.outOp2    = bus.OE ? head[OPERAND_W-1:0]              : 'z;
    assign bus.valid     = valid;
    assign bus.full      = full;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Directed vector table plus hand sequences and a queue scoreboard for the
// prefetch queue.
module tb_ir_prefetch_queue;
    logic clock;
    logic notReset;

    ir_prefetch_queue_if #(.WIDTH(16), .DEPTH(4), .OPCODE_W(7), .OPERAND_W(3)) bus ();

    ir_prefetch_queue #(.WIDTH(16), .DEPTH(4), .OPCODE_W(7), .OPERAND_W(3)) dut (
        .clock    (clock),
        .notReset (notReset),
        .bus      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        nl, na, nf;
        logic [15:0] din;
        logic        ev, ef;
        logic [2:0]  ec;
        logic [15:0] eh;
    } vec_t;

    vec_t vecs [40];
    int   nvec;
    int   tests;
    int   fails;
    logic [15:0] sb [$];

    function automatic logic [15:0] hd();
        return {bus.outOpcode, bus.outOp0, bus.outOp1, bus.outOp2};
    endfunction

    function automatic logic [20:0] status();
        return {bus.valid, bus.full, bus.count, hd()};
    endfunction

    // Released fields: Z in a four-state simulator, zero where Z cannot be held.
    function automatic logic released();
        logic [15:0] v;
        v = hd();
        return (v === 16'hzzzz) || (v === 16'h0000);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic nl, na, nf, input logic [15:0] din,
                       input logic ev, ef, input logic [2:0] ec, input logic [15:0] eh);
        vecs[nvec] = '{nl: nl, na: na, nf: nf, din: din, ev: ev, ef: ef, ec: ec, eh: eh};
        nvec++;
    endtask

    task automatic drive(input logic nl, na, nf, input logic [15:0] din);
        bus.notLoad    = nl;
        bus.notAdvance = na;
        bus.notFlush   = nf;
        bus.in         = din;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [15:0] w;
        tests = 0;
        fails = 0;
        nvec  = 0;

        // nl na nf  din       valid full cnt head
        add(0, 1, 1, 16'hF0F0, 1, 0, 1, 16'hF0F0);
        add(1, 0, 1, 16'h0000, 0, 0, 0, 16'h0000);
        add(1, 0, 1, 16'h0000, 0, 0, 0, 16'h0000);
        add(0, 1, 1, 16'h0001, 1, 0, 1, 16'h0001);
        add(0, 1, 1, 16'h0002, 1, 0, 2, 16'h0001);
        add(0, 1, 1, 16'h0003, 1, 0, 3, 16'h0001);
        add(0, 1, 1, 16'h0004, 1, 1, 4, 16'h0001);
        add(0, 1, 1, 16'h0005, 1, 1, 4, 16'h0001);
        add(1, 0, 1, 16'h0000, 1, 0, 3, 16'h0002);
        add(1, 0, 1, 16'h0000, 1, 0, 2, 16'h0003);
        add(1, 0, 1, 16'h0000, 1, 0, 1, 16'h0004);
        add(1, 0, 1, 16'h0000, 0, 0, 0, 16'h0000);
        add(1, 0, 1, 16'h0000, 0, 0, 0, 16'h0000);
        add(0, 1, 1, 16'h1111, 1, 0, 1, 16'h1111);
        add(0, 1, 1, 16'h2222, 1, 0, 2, 16'h1111);
        add(0, 1, 1, 16'h3333, 1, 0, 3, 16'h1111);
        add(0, 1, 1, 16'h4444, 1, 1, 4, 16'h1111);
        add(0, 0, 1, 16'hAAAA, 1, 1, 4, 16'h2222);
        add(1, 0, 1, 16'h0000, 1, 0, 3, 16'h3333);
        add(1, 0, 1, 16'h0000, 1, 0, 2, 16'h4444);
        add(1, 0, 1, 16'h0000, 1, 0, 1, 16'hAAAA);
        add(1, 0, 1, 16'h0000, 0, 0, 0, 16'h0000);
        add(0, 0, 1, 16'h5555, 1, 0, 1, 16'h5555);
        add(1, 0, 1, 16'h0000, 0, 0, 0, 16'h0000);
        add(0, 1, 1, 16'h0101, 1, 0, 1, 16'h0101);
        add(0, 1, 1, 16'h0202, 1, 0, 2, 16'h0101);
        add(0, 1, 1, 16'h0303, 1, 0, 3, 16'h0101);
        add(0, 0, 0, 16'hBEEF, 0, 0, 0, 16'h0000);
        add(0, 1, 1, 16'hC0DE, 1, 0, 1, 16'hC0DE);
        add(1, 0, 1, 16'h0000, 0, 0, 0, 16'h0000);

        bus.OE   = 1'b1;
        notReset = 1'b0;
        drive(1, 1, 1, 16'h0000);
        #12;
        check("reset_state", 32'(status()), 32'h0);
        tick();
        notReset = 1'b1;

        for (int i = 0; i < nvec; i++) begin
            drive(vecs[i].nl, vecs[i].na, vecs[i].nf, vecs[i].din);
            tick();
            check($sformatf("vec%0d", i), 32'(status()),
                  32'({vecs[i].ev, vecs[i].ef, vecs[i].ec, vecs[i].eh}));
        end

        // Field slicing of a single loaded word.
        w = 16'hF0F0;
        drive(0, 1, 1, w);
        tick();
        drive(1, 1, 1, 16'h0000);
        check("opcode", 32'(bus.outOpcode), 32'(w[15:9]));
        check("op0",    32'(bus.outOp0),    32'(w[8:6]));
        check("op1",    32'(bus.outOp1),    32'(w[5:3]));
        check("op2",    32'(bus.outOp2),    32'(w[2:0]));
        drive(1, 0, 1, 16'h0000);
        tick();
        check("single_pop", 32'(status()), 32'h0);

        // Scoreboard run with mixed occupancy; pointers wrap several times.
        sb.delete();
        for (int c = 0; c < 40; c++) begin
            logic nl, na, pop_ok, push_ok;
            logic [15:0] d;
            nl = ($urandom_range(0, 9) < 6) ? 1'b0 : 1'b1;
            na = ($urandom_range(0, 9) < 5) ? 1'b0 : 1'b1;
            d  = 16'($urandom_range(0, 65535));
            pop_ok  = !na && (sb.size() > 0);
            push_ok = !nl && ((sb.size() < 4) || pop_ok);
            if (pop_ok)  void'(sb.pop_front());
            if (push_ok) sb.push_back(d);
            drive(nl, na, 1, d);
            tick();
            check($sformatf("sb_cyc%0d", c), 32'(status()),
                  32'({sb.size() > 0, sb.size() == 4, 3'(sb.size()),
                       (sb.size() > 0) ? sb[0] : 16'h0000}));
        end
        drive(0, 1, 0, 16'h0000);
        tick();
        check("sb_flush", 32'(status()), 32'h0);

        // OE and asynchronous reset.
        drive(0, 1, 1, 16'h1234);
        tick();
        drive(0, 1, 1, 16'h5678);
        tick();
        drive(1, 1, 1, 16'h0000);
        bus.OE = 1'b0;
        #1;
        check("oe_off_fields", 32'(released()), 32'h1);
        check("oe_off_status", 32'({bus.valid, bus.full, bus.count}), 32'({1'b1, 1'b0, 3'd2}));
        bus.OE = 1'b1;
        #1;
        check("oe_on_head", 32'(hd()), 32'h1234);
        drive(0, 0, 1, 16'h7777);
        notReset = 1'b0;
        #1;
        check("async_reset", 32'(status()), 32'h0);
        bus.OE = 1'b0;
        #1;
        check("reset_oe_off", 32'(released()), 32'h1);
        bus.OE = 1'b1;
        #1;
        check("reset_oe_on", 32'(hd()), 32'h0);
        tick();
        check("reset_hold", 32'(status()), 32'h0);
        drive(0, 1, 1, 16'h9ABC);
        notReset = 1'b1;
        tick();
        drive(1, 1, 1, 16'h0000);
        check("first_push_after_reset", 32'(status()), 32'({1'b1, 1'b0, 3'd1, 16'h9ABC}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
